// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared types and helpers for the button debouncer
//
// Purpose : FSM state encoding and the qualification-counter width helper.
// Ports   : none (package)
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    QUAL_HI   = 2'b01,
    STABLE_HI = 2'b10,
    QUAL_LO   = 2'b11
  } deb_state_t;

  // Smallest width w with 2**w >= n, never less than 1 bit.
  function automatic int cnt_width(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for an asynchronous single-bit input
//
// Purpose : brings an asynchronous level into the clk domain.
// Ports   : clk   - sampling clock
//           rst_n - asynchronous active-low reset, both stages load RESET_VAL
//           d     - asynchronous input
//           q     - synchronized output (second stage)
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - debounces a bouncing switch input with edge pulses
//
// Purpose : synchronizes d_raw, then requires STABLE_CYCLES consecutive
//           synchronized samples of a new level before q follows it.
// Ports   : clk    - clock
//           rst_n  - asynchronous active-low reset
//           d_raw  - raw bouncing input
//           q      - debounced level (registered)
//           rise_p - one-cycle pulse coincident with q going 0->1
//           fall_p - one-cycle pulse coincident with q going 1->0
//           busy   - high while a candidate change is being qualified
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int   STABLE_CYCLES = 4,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_raw,
  output logic q,
  output logic rise_p,
  output logic fall_p,
  output logic busy
);

  localparam int             CW        = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(STABLE_CYCLES - 1);
  localparam deb_state_t     RST_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

  logic          w_d_sync;
  deb_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_q;
  logic          r_rise;
  logic          r_fall;
  logic          r_busy;

  sync_2ff #(
    .RESET_VAL (RESET_LEVEL)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (d_raw),
    .q     (w_d_sync)
  );

  // The counter holds the number of consecutive new-level samples seen so far;
  // entering a QUAL state already counts the first one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RST_STATE;
      r_cnt   <= '0;
      r_q     <= RESET_LEVEL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        STABLE_LO: begin
          r_q    <= 1'b0;
          r_cnt  <= '0;
          r_busy <= 1'b0;
          if (w_d_sync) begin
            r_state <= QUAL_HI;
            r_cnt   <= CNT_ONE;
            r_busy  <= 1'b1;
          end
        end
        QUAL_HI: begin
          if (!w_d_sync) begin
            r_state <= STABLE_LO;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= STABLE_HI;
            r_cnt   <= '0;
            r_q     <= 1'b1;
            r_rise  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        STABLE_HI: begin
          r_q    <= 1'b1;
          r_cnt  <= '0;
          r_busy <= 1'b0;
          if (!w_d_sync) begin
            r_state <= QUAL_LO;
            r_cnt   <= CNT_ONE;
            r_busy  <= 1'b1;
          end
        end
        QUAL_LO: begin
          if (w_d_sync) begin
            r_state <= STABLE_HI;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= STABLE_LO;
            r_cnt   <= '0;
            r_q     <= 1'b0;
            r_fall  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        // Corrupted state: fall back to the stable state that agrees with q.
        default: begin
          r_state <= r_q ? STABLE_HI : STABLE_LO;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign q      = r_q;
  assign rise_p = r_rise;
  assign fall_p = r_fall;
  assign busy   = r_busy;

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - self-checking bench for button_debouncer
module tb_button_debouncer;

  typedef struct {
    logic d;
    logic q;
    logic r;
    logic f;
    logic b;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic d_raw;
  logic q;
  logic rise_p;
  logic fall_p;
  logic busy;
  logic dff_q;

  int errors = 0;
  int checks = 0;

  vec_t vecs[$];

  button_debouncer #(
    .STABLE_CYCLES (4),
    .RESET_LEVEL   (1'b0)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_raw  (d_raw),
    .q      (q),
    .rise_p (rise_p),
    .fall_p (fall_p),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // Downstream rising-edge flip-flop fed by q.
  always @(posedge clk) dff_q <= q;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic add(input logic d, input logic eq, input logic er,
                     input logic ef, input logic eb);
    vec_t v;
    v.d = d; v.q = eq; v.r = er; v.f = ef; v.b = eb;
    vecs.push_back(v);
  endtask

  task automatic step(input logic d);
    @(negedge clk);
    d_raw = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic prev_q;

    // Vectors: d_raw applied before an edge, expected outputs just after it.
    // Clean rise: q rises on the 6th edge sampling the new level.
    for (int i = 0; i < 2; i++) add(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 1);
    add(1, 1, 1, 0, 0);
    add(1, 1, 0, 0, 0);
    // Clean fall.
    for (int i = 0; i < 2; i++) add(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 1);
    add(0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0);
    // 1 x3, 0 x1 (drop lands when counter==3), then 1 held.
    add(1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1);
    add(1, 0, 0, 0, 1);
    add(1, 0, 0, 0, 1);
    add(1, 1, 1, 0, 0);
    add(1, 1, 0, 0, 0);
    // Single-cycle low glitch while high.
    add(0, 1, 0, 0, 0);
    add(1, 1, 0, 0, 0);
    add(1, 1, 0, 0, 1);
    add(1, 1, 0, 0, 0);

    rst_n = 1'b0;
    d_raw = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_q", q, 1'b0);
    check("reset_rise", rise_p, 1'b0);
    check("reset_fall", fall_p, 1'b0);
    check("reset_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    prev_q = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].d);
      check($sformatf("v%0d_q", i), q, vecs[i].q);
      check($sformatf("v%0d_rise", i), rise_p, vecs[i].r);
      check($sformatf("v%0d_fall", i), fall_p, vecs[i].f);
      check($sformatf("v%0d_busy", i), busy, vecs[i].b);
      check($sformatf("v%0d_dff", i), dff_q, prev_q);
      prev_q = vecs[i].q;
    end

    // Reset in the middle of a QUAL_LO qualification.
    step(1'b0);
    step(1'b0);
    step(1'b0);
    check("qlo_busy", busy, 1'b1);
    check("qlo_q", q, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_q", q, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_fall", fall_p, 1'b0);
    check("midrst_rise", rise_p, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("inrst_fall", fall_p, 1'b0);
    check("inrst_q", q, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1'b0);
      check($sformatf("postrst%0d_q", i), q, 1'b0);
      check($sformatf("postrst%0d_fall", i), fall_p, 1'b0);
      check($sformatf("postrst%0d_busy", i), busy, 1'b0);
    end

    // Input already high when reset releases: nothing moves before edge 3.
    @(negedge clk);
    rst_n = 1'b0;
    d_raw = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_e1_busy", busy, 1'b0);
    @(posedge clk); #1;
    check("rel_e2_busy", busy, 1'b0);
    @(posedge clk); #1;
    check("rel_e3_busy", busy, 1'b1);
    check("rel_e3_q", q, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rel_e5_busy", busy, 1'b1);
    @(posedge clk); #1;
    check("rel_e6_q", q, 1'b1);
    check("rel_e6_rise", rise_p, 1'b1);
    check("rel_e6_busy", busy, 1'b0);
    @(posedge clk); #1;
    check("rel_e7_rise", rise_p, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
